bus_reg_bank: RTL and testbench
===============================

# bus_reg_bank

Parametrised bank of M N-bit registers sharing one tri-state data bus, the successor to the single-register tri-state bus output stage. Supports direct writes, bus reads and bus captures from outside, plus an internal register-to-register transfer over the bus run by a small state machine with drive, latch and turnaround phases. Sits on the datapath bus alongside other tri-state drivers. Only one driver may be active per cycle.

## Interface
- N, default 8: register and bus width.
- M, default 4: number of registers (M ≥ 2). Address width A = $clog2(M).

- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- bus  inout  N  shared tri-state data bus. The block drives it or releases it to 'z.
- wr_en  input  1  direct write of d into reg[addr].
- d  input  N  direct write data.
- addr  input  A  register select for wr_en, rd_en and bus_ld.
- rd_en  input  1  drive reg[addr] onto bus.
- bus_ld  input  1  capture bus into reg[addr].
- start  input  1  request transfer reg[src] → reg[dst].
- src  input  A  transfer source, sampled with start.
- dst  input  A  transfer destination, sampled with start.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- q  output  N  combinational view of reg[addr], for debug and monitoring.

## Operation
- **Reset** (reset=1 at clk edge):
  - All registers are cleared to 0.
  - FSM goes to IDLE.
  - busy=0, done=0, bus='z.
  - Reset mid-transfer aborts the transfer: no dst update and no done pulse.
- **FSM states and transitions:**
  - IDLE → DRIVE when start=1. src and dst are latched into internal registers on that edge.
  - DRIVE → LATCH unconditionally.
  - LATCH → RELEASE unconditionally. reg[dst] ← bus on the exit edge.
  - RELEASE → IDLE unconditionally.
- **Bus drive:**
  - DRIVE and LATCH: bus = reg[src_latched].
  - IDLE with rd_en=1: bus = reg[addr].
  - Otherwise bus='z, including in RELEASE, which is the turnaround cycle.
- **External ops in IDLE**, lowest to highest priority: rd_en, bus_ld, wr_en.
  - If wr_en and bus_ld are both active, wr_en wins.
  - start=1 in IDLE takes precedence over rd_en. No drive occurs that cycle.
  - wr_en and bus_ld in the same cycle as an accepted start still execute.
- **External ops while busy:**
  - start is ignored. It is not queued.
  - rd_en and bus_ld are ignored.
  - wr_en still executes, except when addr == dst_latched on the LATCH exit edge. There the transfer wins.
  - wr_en to src during DRIVE changes the value captured at LATCH: the dst receives the bus value present in the LATCH cycle.
- **Edge cases:**
  - src == dst is legal. The transfer completes normally and the value is unchanged.
  - Out-of-range addresses (when M is not a power of two): writes are dropped, the bank does not drive, and q reads 0.

## Timing
- Cycle 0: start=1 sampled.
- Cycle 1 (DRIVE): busy=1, bus = reg[src].
- Cycle 2 (LATCH): bus is still driven. reg[dst] is updated at the end of cycle 2.
- Cycle 3 (RELEASE): bus='z, done=1, new value visible on q when addr=dst.
- Cycle 4: IDLE, busy=0. A new start is accepted from cycle 4.
- Transfer latency is 3 cycles from start to done. Throughput is one transfer per 4 cycles.
- busy is a registered output, high in exactly DRIVE, LATCH and RELEASE.
- done is registered and high only in RELEASE.
- rd_en drive is combinational from state, rd_en and addr, so it is valid in the same cycle.
- bus_ld and wr_en take effect on the next edge.

## Test plan
1. **Reset:** write 0xA5 to reg2, then assert reset for 1 cycle → q=0x00 for every addr, busy=0, done=0, bus='z.
2. **Direct write and read:** wr_en, addr=1, d=0x3C; then rd_en, addr=1 → bus=0x3C in the same cycle. With rd_en=0 → bus='z.
3. **Transfer:** reg0=0x11, start with src=0, dst=3 →
   - busy high cycles 1–3, bus=0x11 in cycles 1–2, bus='z in cycle 3.
   - done pulses in cycle 3, reg3=0x11 from cycle 3.
   - A start applied in cycles 1–3 is ignored.
4. **Write/transfer collision:** during a transfer 0→3 with reg0=0x11, wr_en addr=3 d=0xFF in the LATCH cycle → reg3=0x11. The same write in DRIVE → reg3=0x11 (overwritten at LATCH). A write to addr=2 in LATCH → reg2=0xFF.
5. **Bus capture:** external driver puts 0x5A on bus, bus_ld with addr=2 → reg2=0x5A. bus_ld and wr_en (d=0x77) together → reg2=0x77.
6. **Reset mid-transfer:** assert reset in the DRIVE cycle of transfer 1→0 → no done pulse, all registers 0, bus='z, and a fresh start is accepted on the next cycle.

Source files
------------

// File: rtl/bus_reg_bank.sv
// Bank of M N-bit registers on a shared tri-state bus with an internal
// reg-to-reg transfer sequencer (drive, latch, turnaround); 3 cycles start->done.
module bus_reg_bank #(
   parameter int N = 8,
   parameter int M = 4,
   localparam int A = $clog2(M)
) (
   input  logic         clk,
   input  logic         reset,
   inout  wire  [N-1:0] bus,
   input  logic         wr_en,
   input  logic [N-1:0] d,
   input  logic [A-1:0] addr,
   input  logic         rd_en,
   input  logic         bus_ld,
   input  logic         start,
   input  logic [A-1:0] src,
   input  logic [A-1:0] dst,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] q
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DRIVE   = 2'd1;
   localparam logic [1:0] S_LATCH   = 2'd2;
   localparam logic [1:0] S_RELEASE = 2'd3;

   logic [N-1:0] regs [M];
   logic [1:0]   state;
   logic [A-1:0] src_l;
   logic [A-1:0] dst_l;
   logic         addr_ok;
   logic         src_ok;
   logic         dst_ok;
   logic         drive_en;
   logic [N-1:0] drive_dat;

   // Addresses beyond M-1 exist only when M is not a power of two.
   assign addr_ok = 32'(addr)  < 32'(M);
   assign src_ok  = 32'(src_l) < 32'(M);
   assign dst_ok  = 32'(dst_l) < 32'(M);

   always_comb begin
      drive_en  = 1'b0;
      drive_dat = '0;
      if ((state == S_DRIVE || state == S_LATCH) && src_ok) begin
         drive_en  = 1'b1;
         drive_dat = regs[src_l];
      end else if (state == S_IDLE && rd_en && !start && addr_ok) begin
         drive_en  = 1'b1;
         drive_dat = regs[addr];
      end
   end

   assign bus = drive_en ? drive_dat : {N{1'bz}};
   assign q   = addr_ok ? regs[addr] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         src_l <= '0;
         dst_l <= '0;
         for (int i = 0; i < M; i++) begin
            regs[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_DRIVE;
                  busy  <= 1'b1;
                  src_l <= src;
                  dst_l <= dst;
               end
            end
            S_DRIVE: state <= S_LATCH;
            S_LATCH: begin
               state <= S_RELEASE;
               done  <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase

         // Later assignments win: bus capture < direct write < transfer latch.
         if (state == S_IDLE && bus_ld && addr_ok) begin
            regs[addr] <= bus;
         end
         if (wr_en && addr_ok && !(state == S_LATCH && addr == dst_l)) begin
            regs[addr] <= d;
         end
         if (state == S_LATCH && dst_ok) begin
            regs[dst_l] <= bus;
         end
      end
   end

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed bench for bus_reg_bank: reset, direct access, transfers,
// write/transfer collisions, bus capture and reset mid-transfer.
module tb_bus_reg_bank;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] d = '0;
   logic [1:0] addr = '0;
   logic       rd_en = 1'b0;
   logic       bus_ld = 1'b0;
   logic       start = 1'b0;
   logic [1:0] src = '0;
   logic [1:0] dst = '0;
   logic       busy;
   logic       done;
   logic [7:0] q;
   logic       tb_oe = 1'b0;
   logic [7:0] tb_drv = '0;
   wire  [7:0] bus;

   int n_cmp = 0;
   int n_err = 0;

   // A released bus reads z in four-state simulators and 0 in two-state ones.
   assign bus = tb_oe ? tb_drv : 8'hzz;

   always #5 clk = ~clk;

   bus_reg_bank #(.N(8), .M(4)) dut (
      .clk(clk), .reset(reset), .bus(bus), .wr_en(wr_en), .d(d), .addr(addr),
      .rd_en(rd_en), .bus_ld(bus_ld), .start(start), .src(src), .dst(dst),
      .busy(busy), .done(done), .q(q)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] v);
      wr_en = 1'b1; addr = a; d = v;
      tick();
      wr_en = 1'b0;
   endtask

   // Transfer s->t with an optional direct write in DRIVE (wcyc=1) or LATCH (wcyc=2).
   task automatic xfer(input logic [1:0] s, input logic [1:0] t, input int wcyc,
                       input logic [1:0] wa, input logic [7:0] wv);
      start = 1'b1; src = s; dst = t;
      tick();
      start = 1'b0;
      if (wcyc == 1) begin wr_en = 1'b1; addr = wa; d = wv; end
      tick();
      wr_en = 1'b0;
      if (wcyc == 2) begin wr_en = 1'b1; addr = wa; d = wv; end
      tick();
      wr_en = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(); tick(); reset = 1'b0;
      wr(2'd2, 8'hA5);
      addr = 2'd2; #1;
      n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL pre_reset_q2: got %h want a5", q); end
      reset = 1'b1; tick(); reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         addr = 2'(a); #1;
         n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL reset_q%0d: got %h want 00", a, q); end
      end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (bus !== 8'h00 && bus !== 8'hzz) begin n_err++; $display("FAIL reset_bus: got %h want released", bus); end
   endtask

   task automatic test_write_read();
      wr(2'd1, 8'h3C);
      rd_en = 1'b1; addr = 2'd1; #1;
      n_cmp++; if (bus !== 8'h3C) begin n_err++; $display("FAIL rd_drive: got %h want 3c", bus); end
      n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL rd_q: got %h want 3c", q); end
      rd_en = 1'b0; #1;
      n_cmp++; if (bus !== 8'h00 && bus !== 8'hzz) begin n_err++; $display("FAIL rd_release: got %h want released", bus); end
   endtask

   task automatic test_transfer();
      wr(2'd0, 8'h11); wr(2'd1, 8'h99); wr(2'd2, 8'h00); wr(2'd3, 8'h00);
      start = 1'b1; src = 2'd0; dst = 2'd3; rd_en = 1'b1; addr = 2'd1; #1;
      n_cmp++; if (bus !== 8'h00 && bus !== 8'hzz) begin n_err++; $display("FAIL start_over_rd: got %h want released", bus); end
      tick(); rd_en = 1'b0;
      // start stays high through cycles 1-3 with another request; it must be ignored
      src = 2'd1; dst = 2'd2; addr = 2'd3; #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL c1_busy: got %b want 1", busy); end
      n_cmp++; if (bus !== 8'h11) begin n_err++; $display("FAIL c1_bus: got %h want 11", bus); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL c1_done: got %b want 0", done); end
      tick();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL c2_busy: got %b want 1", busy); end
      n_cmp++; if (bus !== 8'h11) begin n_err++; $display("FAIL c2_bus: got %h want 11", bus); end
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL c2_q3: got %h want 00", q); end
      tick();
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL c3_busy: got %b want 1", busy); end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL c3_done: got %b want 1", done); end
      n_cmp++; if (bus !== 8'h00 && bus !== 8'hzz) begin n_err++; $display("FAIL c3_bus: got %h want released", bus); end
      n_cmp++; if (q !== 8'h11) begin n_err++; $display("FAIL c3_q3: got %h want 11", q); end
      tick(); start = 1'b0; addr = 2'd2; #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL c4_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL c4_done: got %b want 0", done); end
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL ignored_start_q2: got %h want 00", q); end
      // back-to-back: new start accepted in cycle 4
      start = 1'b1; src = 2'd3; dst = 2'd2;
      tick(); start = 1'b0; #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy); end
      n_cmp++; if (bus !== 8'h11) begin n_err++; $display("FAIL b2b_bus: got %h want 11", bus); end
      tick(); tick(); tick(); addr = 2'd2; #1;
      n_cmp++; if (q !== 8'h11) begin n_err++; $display("FAIL b2b_q2: got %h want 11", q); end
   endtask

   task automatic test_collision();
      wr(2'd0, 8'h11); wr(2'd3, 8'h00);
      xfer(2'd0, 2'd3, 2, 2'd3, 8'hFF);
      addr = 2'd3; #1;
      n_cmp++; if (q !== 8'h11) begin n_err++; $display("FAIL latch_wr_dst: got %h want 11", q); end
      wr(2'd3, 8'h00);
      xfer(2'd0, 2'd3, 1, 2'd3, 8'hFF);
      addr = 2'd3; #1;
      n_cmp++; if (q !== 8'h11) begin n_err++; $display("FAIL drive_wr_dst: got %h want 11", q); end
      wr(2'd2, 8'h00); wr(2'd3, 8'h00);
      xfer(2'd0, 2'd3, 2, 2'd2, 8'hFF);
      addr = 2'd2; #1;
      n_cmp++; if (q !== 8'hFF) begin n_err++; $display("FAIL latch_wr_other: got %h want ff", q); end
      addr = 2'd3; #1;
      n_cmp++; if (q !== 8'h11) begin n_err++; $display("FAIL latch_wr_other_dst: got %h want 11", q); end
      xfer(2'd0, 2'd3, 1, 2'd0, 8'h22);
      addr = 2'd3; #1;
      n_cmp++; if (q !== 8'h22) begin n_err++; $display("FAIL drive_wr_src: got %h want 22", q); end
      wr(2'd1, 8'h99);
      xfer(2'd1, 2'd1, 0, 2'd0, 8'h00);
      addr = 2'd1; #1;
      n_cmp++; if (q !== 8'h99) begin n_err++; $display("FAIL src_eq_dst: got %h want 99", q); end
   endtask

   task automatic test_bus_capture();
      tb_oe = 1'b1; tb_drv = 8'h5A; bus_ld = 1'b1; addr = 2'd2;
      tick(); bus_ld = 1'b0; #1;
      n_cmp++; if (q !== 8'h5A) begin n_err++; $display("FAIL bus_ld: got %h want 5a", q); end
      bus_ld = 1'b1; wr_en = 1'b1; d = 8'h77;
      tick(); bus_ld = 1'b0; wr_en = 1'b0; tb_oe = 1'b0; #1;
      n_cmp++; if (q !== 8'h77) begin n_err++; $display("FAIL wr_over_ld: got %h want 77", q); end
   endtask

   task automatic test_reset_mid();
      wr(2'd1, 8'h33); wr(2'd0, 8'h44);
      start = 1'b1; src = 2'd1; dst = 2'd0;
      tick(); start = 1'b0; #1;
      n_cmp++; if (bus !== 8'h33) begin n_err++; $display("FAIL mid_drive_bus: got %h want 33", bus); end
      reset = 1'b1; tick(); reset = 1'b0; #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b want 0", done); end
      n_cmp++; if (bus !== 8'h00 && bus !== 8'hzz) begin n_err++; $display("FAIL mid_bus: got %h want released", bus); end
      for (int a = 0; a < 4; a++) begin
         addr = 2'(a); #1;
         n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL mid_q%0d: got %h want 00", a, q); end
      end
      // fresh start plus a same-cycle write to its source
      start = 1'b1; src = 2'd2; dst = 2'd1; wr_en = 1'b1; addr = 2'd2; d = 8'h66;
      tick(); start = 1'b0; wr_en = 1'b0; #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL fresh_busy: got %b want 1", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL fresh_done_c1: got %b want 0", done); end
      n_cmp++; if (bus !== 8'h66) begin n_err++; $display("FAIL fresh_bus: got %h want 66", bus); end
      tick(); tick(); addr = 2'd1; #1;
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL fresh_done_c3: got %b want 1", done); end
      n_cmp++; if (q !== 8'h66) begin n_err++; $display("FAIL fresh_q1: got %h want 66", q); end
      addr = 2'd0; #1;
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL fresh_q0: got %h want 00", q); end
      tick();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_transfer();
      test_collision();
      test_bus_capture();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
